// File: rtl/egress_scheduler.sv
// Round-robin owner-locked scheduler feeding one word per WORD_GAP clocks to a byte serializer.
// Latency: accept cycle t -> WriteDataValid in t+1. Requesters are throttled through ReqReady (gap, EgReady, EnMask).
module egress_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int WORD_GAP = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                     ClkEngress,
    input  logic                     ARstN,
    input  logic [NUM_REQ-1:0]       ReqValid,
    input  logic [32*NUM_REQ-1:0]    ReqData,
    input  logic [NUM_REQ-1:0]       ReqLast,
    output logic [NUM_REQ-1:0]       ReqReady,
    input  logic [NUM_REQ-1:0]       EnMask,
    input  logic                     EgReady,
    output logic [31:0]              WriteData,
    output logic                     WriteDataValid,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     Busy,
    output logic [15:0]              WordCount
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = $clog2(WORD_GAP);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(WORD_GAP - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MAX - 1);

    typedef enum logic {ST_IDLE, ST_LOCK} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          wvld_q, wvld_d;
    logic [15:0]   wcnt_q, wcnt_d;

    logic [31:0]        req_word [NUM_REQ];
    logic [NUM_REQ-1:0] cand;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    int                 rr_idx;
    logic               owner_rdy;
    logic               xfer;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign req_word[g] = ReqData[32*g +: 32];
    end

    // Search starts just after the last owner so every enabled requester gets a turn.
    always_comb begin
        cand       = ReqValid & EnMask;
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!pick_found && cand[IW'(rr_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        gap_d     = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        hold_d    = hold_q;
        wdata_d   = wdata_q;
        wvld_d    = 1'b0;
        wcnt_d    = wcnt_q;
        owner_rdy = (state_q == ST_LOCK) && (gap_q == '0) && EgReady && EnMask[owner_q];
        xfer      = owner_rdy && ReqValid[owner_q];
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    hold_d  = '0;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    wdata_d = req_word[owner_q];
                    wvld_d  = 1'b1;
                    gap_d   = GAP_RELOAD;
                    wcnt_d  = wcnt_q + 16'd1;
                    hold_d  = '0;
                    if (ReqLast[owner_q]) begin
                        state_d = ST_IDLE;
                        ptr_d   = owner_q;
                    end
                end else if (!EnMask[owner_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                    hold_d  = '0;
                end else if (!ReqValid[owner_q]) begin
                    // An owner that went quiet mid-burst loses the lock after HOLD_MAX idle clocks.
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        ptr_d   = owner_q;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ClkEngress or negedge ARstN) begin
        if (!ARstN) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            gap_q   <= '0;
            hold_q  <= '0;
            wdata_q <= '0;
            wvld_q  <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            wdata_q <= wdata_d;
            wvld_q  <= wvld_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        ReqReady = '0;
        Grant    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ReqReady[i] = owner_rdy && (owner_q == IW'(i));
            Grant[i]    = (state_q == ST_LOCK) && (owner_q == IW'(i));
        end
    end

    assign WriteData      = wdata_q;
    assign WriteDataValid = wvld_q;
    assign WordCount      = wcnt_q;
    assign Busy           = (state_q == ST_LOCK) || (gap_q != '0);

endmodule

// File: tb/tb_egress_scheduler.sv
// Bench for egress_scheduler: directed vector table, corner-case sequences and random traffic vs a behavioural model.
module tb_egress_scheduler;

    localparam int N  = 4;
    localparam int WG = 4;
    localparam int HM = 16;

    logic            clk = 1'b0;
    logic            ARstN;
    logic [N-1:0]    ReqValid, ReqLast, ReqReady, EnMask, Grant;
    logic [32*N-1:0] ReqData;
    logic            EgReady, WriteDataValid, Busy;
    logic [31:0]     WriteData;
    logic [15:0]     WordCount;

    always #5 clk = ~clk;

    egress_scheduler #(.NUM_REQ(N), .WORD_GAP(WG), .HOLD_MAX(HM)) dut (
        .ClkEngress(clk), .ARstN(ARstN), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqLast(ReqLast), .ReqReady(ReqReady), .EnMask(EnMask), .EgReady(EgReady),
        .WriteData(WriteData), .WriteDataValid(WriteDataValid), .Grant(Grant),
        .Busy(Busy), .WordCount(WordCount)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: owner is -1 when nobody holds the serializer.
    int          m_own, m_ptr, m_gap, m_hold, m_wc;
    logic [31:0] m_wd;
    bit          m_wv;

    task automatic m_reset();
        m_own = -1; m_ptr = N - 1; m_gap = 0; m_hold = 0; m_wc = 0; m_wd = '0; m_wv = 0;
    endtask

    function automatic logic [N-1:0] m_rdy();
        logic [N-1:0] r = '0;
        if (m_own >= 0 && m_gap == 0 && EgReady && EnMask[m_own]) r[m_own] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    task automatic m_release();
        m_ptr = m_own; m_own = -1; m_hold = 0;
    endtask

    task automatic m_step();
        logic [N-1:0] r;
        int ng;
        r  = m_rdy();
        ng = (m_gap > 0) ? m_gap - 1 : 0;
        m_wv = 0;
        if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (ReqValid[i] && EnMask[i]) begin
                    m_own = i; m_hold = 0;
                    break;
                end
            end
        end else if (!EnMask[m_own]) begin
            m_release();
        end else if (ReqValid[m_own] && r[m_own]) begin
            m_wd = ReqData[32*m_own +: 32];
            m_wv = 1; ng = WG - 1; m_wc = (m_wc + 1) % 65536; m_hold = 0;
            if (ReqLast[m_own]) m_release();
        end else if (!ReqValid[m_own]) begin
            m_hold++;
            if (m_hold >= HM) m_release();
        end else begin
            m_hold = 0;
        end
        m_gap = ng;
    endtask

    // Requester sources: rem = words left in burst, stall = clocks of silence before next word.
    int rem [N];
    int stall [N];
    int stall_after [N];
    int seq [N];
    bit auto_src;
    logic [N-1:0] last_rdy;

    task automatic present();
        for (int i = 0; i < N; i++) begin
            ReqValid[i] = (rem[i] > 0) && (stall[i] == 0);
            ReqLast[i]  = (rem[i] == 1);
            ReqData[32*i +: 32] = {8'(i), 24'(seq[i])};
        end
    endtask

    // One clock: called at a falling edge, checks ReqReady mid-cycle and registered outputs at the next falling edge.
    task automatic cyc();
        logic [N-1:0] hs;
        if (auto_src) present();
        #1;
        last_rdy = ReqReady;
        chk("ReqReady", ReqReady, m_rdy());
        hs = ReqValid & ReqReady;
        m_step();
        @(posedge clk);
        @(negedge clk);
        chk("Grant", Grant, m_gnt());
        chk("WriteDataValid", WriteDataValid, m_wv);
        chk("WriteData", WriteData, m_wd);
        chk("Busy", Busy, (m_own >= 0 || m_gap != 0));
        chk("WordCount", WordCount, m_wc);
        if (auto_src) begin
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    rem[i]--; seq[i]++; stall[i] = stall_after[i];
                end else if (stall[i] > 0) begin
                    stall[i]--;
                end
            end
        end
    endtask

    task automatic wait_gnt(input logic [N-1:0] g, input string nm, input int budget);
        int k = 0;
        while (Grant !== g && k < budget) begin cyc(); k++; end
        chk(nm, Grant, g);
    endtask

    task automatic wait_strobe(input string nm, input int budget);
        int k = 0;
        do begin cyc(); k++; end while (WriteDataValid !== 1'b1 && k < budget);
        chk(nm, WriteDataValid, 1'b1);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rem[i];
        return s;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while ((Grant !== '0 || pending() != 0) && k < budget) begin cyc(); k++; end
        chk(nm, {Grant, 28'(pending())}, 32'h0);
    endtask

    task automatic do_reset();
        ARstN = 1'b0;
        @(negedge clk);
        ARstN = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic         lst;
        logic [31:0]  dat;
        logic [N-1:0] rdy;
        logic [N-1:0] gnt;
        logic         wv;
        logic [31:0]  wd;
        logic [15:0]  wc;
    } vec_t;

    vec_t tv [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        localparam logic [31:0] A0 = 32'hA000_0000;
        localparam logic [31:0] A1 = 32'hA000_0001;
        localparam logic [31:0] A2 = 32'hA000_0002;
        int strobe_at [$];
        int order [4];
        int ng;
        logic [N-1:0] prev_g, bad13, rdy_or;
        bit saw1, nost;
        int drop;

        tv[0]  = '{4'b0001, 1'b0, A0, 4'b0000, 4'b0001, 1'b0, 32'h0, 16'd0};
        tv[1]  = '{4'b0001, 1'b0, A0, 4'b0001, 4'b0001, 1'b1, A0,    16'd1};
        tv[2]  = '{4'b0001, 1'b0, A1, 4'b0000, 4'b0001, 1'b0, A0,    16'd1};
        tv[3]  = '{4'b0001, 1'b0, A1, 4'b0000, 4'b0001, 1'b0, A0,    16'd1};
        tv[4]  = '{4'b0001, 1'b0, A1, 4'b0000, 4'b0001, 1'b0, A0,    16'd1};
        tv[5]  = '{4'b0001, 1'b0, A1, 4'b0001, 4'b0001, 1'b1, A1,    16'd2};
        tv[6]  = '{4'b0001, 1'b1, A2, 4'b0000, 4'b0001, 1'b0, A1,    16'd2};
        tv[7]  = '{4'b0001, 1'b1, A2, 4'b0000, 4'b0001, 1'b0, A1,    16'd2};
        tv[8]  = '{4'b0001, 1'b1, A2, 4'b0000, 4'b0001, 1'b0, A1,    16'd2};
        tv[9]  = '{4'b0001, 1'b1, A2, 4'b0001, 4'b0000, 1'b1, A2,    16'd3};
        tv[10] = '{4'b0000, 1'b0, 32'h0, 4'b0000, 4'b0000, 1'b0, A2, 16'd3};

        for (int i = 0; i < N; i++) begin
            rem[i] = 0; stall[i] = 0; stall_after[i] = 0; seq[i] = 0;
        end
        auto_src = 0;
        ARstN = 1'b0; ReqValid = '0; ReqLast = '0; ReqData = '0; EnMask = '1; EgReady = 1'b1;
        m_reset();

        // Reset held with random inputs: everything must stay quiet.
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            ReqValid = N'($urandom); ReqLast = N'($urandom); EnMask = N'($urandom);
            EgReady = 1'($urandom); ReqData = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("rst_ReqReady", ReqReady, '0);
            chk("rst_outs", {WriteData[15:0], WordCount}, 32'h0);
            chk("rst_flags", {Grant, WriteDataValid, Busy, WriteData[31:16] != 16'h0}, '0);
            @(negedge clk);
        end
        ReqValid = '0; ReqLast = '0; ReqData = '0; EnMask = '1; EgReady = 1'b1;
        ARstN = 1'b1;
        cyc();
        chk("rst_release_grant", Grant, '0);

        // Req0 three-word burst, hand-derived per-cycle expectations.
        for (int k = 0; k < 11; k++) begin
            ReqValid = tv[k].vld; ReqLast = {3'b000, tv[k].lst}; ReqData = '0; ReqData[31:0] = tv[k].dat;
            cyc();
            chk("tv_ReqReady", last_rdy, tv[k].rdy);
            chk("tv_Grant", Grant, tv[k].gnt);
            chk("tv_WriteDataValid", WriteDataValid, tv[k].wv);
            chk("tv_WriteData", WriteData, tv[k].wd);
            chk("tv_WordCount", WordCount, tv[k].wc);
            if (WriteDataValid) strobe_at.push_back(k);
        end
        chk("tv_nstrobes", strobe_at.size(), 3);
        if (strobe_at.size() == 3) begin
            chk("tv_spacing01", strobe_at[1] - strobe_at[0], WG);
            chk("tv_spacing12", strobe_at[2] - strobe_at[1], WG);
        end

        // Req0 and req2 with back-to-back single-word bursts: alternate from req0.
        auto_src = 1;
        do_reset();
        ng = 0; prev_g = '0; bad13 = '0;
        for (int k = 0; k < 200 && ng < 4; k++) begin
            if (rem[0] == 0) rem[0] = 1;
            if (rem[2] == 0) rem[2] = 1;
            cyc();
            bad13 |= Grant & 4'b1010;
            if (Grant != '0 && prev_g == '0) begin
                for (int i = 0; i < N; i++) if (Grant[i]) order[ng] = i;
                ng++;
            end
            prev_g = Grant;
        end
        chk("rr_ngrants", ng, 4);
        for (int i = 0; i < 4; i++) chk("rr_order", order[i], (i % 2 == 0) ? 0 : 2);
        chk("rr_never_1_3", bad13, '0);
        wait_idle("rr_drain", 60);

        // Masked requester is skipped until its enable returns.
        EnMask = 4'b1101; rem[1] = 1; saw1 = 0;
        for (int k = 0; k < 20; k++) begin cyc(); saw1 |= Grant[1]; end
        chk("mask_no_grant1", saw1, 1'b0);
        EnMask = 4'b1111;
        wait_gnt(4'b0010, "mask_grant1", 10);
        wait_idle("mask_drain", 40);

        // Owner goes quiet after one word: lock released after HOLD_MAX clocks.
        stall_after[3] = 200; rem[3] = 2;
        wait_gnt(4'b1000, "hold_grant3", 10);
        rem[0] = 1;
        wait_strobe("hold_first_word", 10);
        nost = 1; drop = -1;
        for (int k = 1; k <= HM; k++) begin
            cyc();
            if (WriteDataValid) nost = 0;
            if (Grant == '0 && drop < 0) drop = k;
        end
        chk("hold_release_clk", drop, HM);
        chk("hold_no_strobe", nost, 1'b1);
        cyc();
        chk("hold_next_grant0", Grant, 4'b0001);
        rem[3] = 0; stall[3] = 0; stall_after[3] = 0;
        wait_idle("hold_drain", 40);

        // Serializer not ready mid-burst, then an asynchronous reset with a strobe in flight.
        rem[1] = 8;
        wait_gnt(4'b0010, "egr_grant1", 10);
        wait_strobe("egr_first", 10);
        EgReady = 1'b0; nost = 1; rdy_or = '0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (WriteDataValid) nost = 0;
            rdy_or |= last_rdy;
        end
        chk("egr_no_strobe", nost, 1'b1);
        chk("egr_no_ready", rdy_or, '0);
        EgReady = 1'b1;
        wait_strobe("egr_resume", 10);
        #2 ARstN = 1'b0;
        #1;
        chk("arst_wvld", WriteDataValid, 1'b0);
        chk("arst_grant", Grant, '0);
        chk("arst_busy", Busy, 1'b0);
        chk("arst_wcnt", WordCount, 16'h0);
        chk("arst_wdata", WriteData, 32'h0);
        chk("arst_ready", ReqReady, '0);
        @(negedge clk);
        ARstN = 1'b1;
        m_reset();
        rem[0] = 1; rem[2] = 1;
        begin
            int k = 0;
            while (Grant === '0 && k < 10) begin cyc(); k++; end
        end
        chk("arst_next_grant0", Grant, 4'b0001);
        wait_idle("arst_drain", 300);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
                stall_after[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
            end
            EgReady = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) EnMask = N'($urandom);
            cyc();
        end
        EnMask = '1; EgReady = 1'b1;
        for (int i = 0; i < N; i++) stall_after[i] = 0;
        wait_idle("rand_drain", 800);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
